// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: op encodings, FSM states, sizing helper.
package alu_pkg;

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpMul = 2'b10,
    OpDiv = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StStart,
    StHold,
    StWait,
    StResp
  } seq_state_e;

  // Bits needed to count 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// WAIT-phase cycle counter: counts while run_i is high, clears otherwise, flags the limit.
module alu_seq_timer #(
  parameter int unsigned Width = 6,
  parameter int unsigned Limit = 63
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic done_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb count_d = run_i ? count_q + Width'(1) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == Width'(Limit));

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one command at a time through an external multi-cycle ALU:
// clear, start with the first operand, hold, then wait for finish or timeout.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 63,
  parameter int unsigned M_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_x,
  input  logic [7:0]  cmd_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_of,
  output logic        rsp_timeout,
  output logic        alu_rst,
  output logic        alu_start,
  output logic [1:0]  alu_sel,
  output logic [15:0] alu_inbus,
  input  logic [15:0] alu_outbus,
  input  logic        alu_finish,
  input  logic        alu_of_flag
);

  localparam int unsigned TimerWidth = cnt_width(TIMEOUT);
  localparam int unsigned HoldWidth  = cnt_width(M_DELAY);

  seq_state_e             state_q, state_d;
  alu_op_e                op_q, op_d;
  logic [15:0]            x_q, x_d;
  logic [7:0]             y_q, y_d;
  logic [HoldWidth-1:0]   hold_q, hold_d;
  logic [15:0]            data_q, data_d;
  logic                   of_q, of_d;
  logic                   to_q, to_d;
  logic                   timer_done;
  logic [15:0]            x_bus;

  alu_seq_timer #(
    .Width(TimerWidth),
    .Limit(TIMEOUT)
  ) u_timer (
    .clk_i (clk),
    .rst_ni(rst),
    .run_i (state_q == StWait),
    .done_o(timer_done)
  );

  // Only divide consumes a full 16-bit dividend; the others see the low byte.
  always_comb x_bus = (op_q == OpDiv) ? x_q : {8'h00, x_q[7:0]};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    x_d       = x_q;
    y_d       = y_q;
    hold_d    = hold_q;
    data_d    = data_q;
    of_d      = of_q;
    to_d      = to_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_rst   = !rst;
    alu_start = 1'b0;
    alu_sel   = 2'b00;
    alu_inbus = 16'h0000;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = alu_op_e'(cmd_op);
          x_d     = cmd_x;
          y_d     = cmd_y;
          of_d    = 1'b0;
          to_d    = 1'b0;
          state_d = StClr;
        end
      end
      StClr: begin
        alu_rst = 1'b1;
        state_d = StStart;
      end
      StStart: begin
        alu_start = 1'b1;
        alu_sel   = op_q;
        alu_inbus = x_bus;
        of_d      = of_q | alu_of_flag;
        hold_d    = '0;
        state_d   = (M_DELAY == 0) ? StWait : StHold;
      end
      StHold: begin
        alu_sel   = op_q;
        alu_inbus = x_bus;
        of_d      = of_q | alu_of_flag;
        hold_d    = hold_q + HoldWidth'(1);
        if (hold_q == HoldWidth'(M_DELAY - 1)) begin
          state_d = StWait;
        end
      end
      StWait: begin
        alu_sel   = op_q;
        alu_inbus = {8'h00, y_q};
        // A finish on the terminal cycle still counts as a completed operation.
        if (alu_finish) begin
          data_d  = alu_outbus;
          of_d    = of_q | alu_of_flag;
          to_d    = 1'b0;
          state_d = StResp;
        end else if (timer_done) begin
          data_d  = 16'h0000;
          of_d    = 1'b0;
          to_d    = 1'b1;
          state_d = StResp;
        end else begin
          of_d = of_q | alu_of_flag;
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      op_q    <= OpAdd;
      x_q     <= 16'h0000;
      y_q     <= 8'h00;
      hold_q  <= '0;
      data_q  <= 16'h0000;
      of_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      of_q    <= of_d;
      to_q    <= to_d;
    end
  end

  assign rsp_data    = data_q;
  assign rsp_of      = of_q;
  assign rsp_timeout = to_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 63, max WAIT cycles before aborting an operation.
REQ-002 SHALL have parameter M_DELAY, default 1, cycles first operand is held after start before M is driven.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-007 SHALL have port cmd_op  input  2  00 add, 01 sub, 10 mul, 11 div.
REQ-008 SHALL have port cmd_x  input  16  first operand (A for add/sub, Q for mul, A.Q dividend for div).
REQ-009 SHALL have port cmd_y  input  8  second operand M.
REQ-010 SHALL have port rsp_valid  output  1  result available.
REQ-011 SHALL have port rsp_ready  input  1  result consumed when rsp_valid & rsp_ready.
REQ-012 SHALL have port rsp_data  output  16  captured ALU outbus.
REQ-013 SHALL have port rsp_of  output  1  overflow seen during the operation.
REQ-014 SHALL have port rsp_timeout  output  1  operation aborted, no finish.
REQ-015 SHALL have port alu_rst  output  1  active-high clear to the ALU.
REQ-016 SHALL have ports alu_start (output 1), alu_sel (output 2), alu_inbus (output 16), driving the ALU.
REQ-017 SHALL have ports alu_outbus (input 16), alu_finish (input 1), alu_of_flag (input 1), from the ALU.

Function
REQ-018 SHALL implement states IDLE, CLR, START, HOLD, WAIT, RESP.
REQ-019 IDLE: cmd_ready=1; on handshake, register op/x/y, go CLR; all ALU outputs inactive, alu_inbus=0.
REQ-020 CLR: alu_rst=1 for exactly one cycle, then START.
REQ-021 START: alu_start=1, alu_sel=op, alu_inbus=x for exactly one cycle, then HOLD.
REQ-022 alu_inbus for op 00/01/10 SHALL be {8'h00, x[7:0]}; for op 11 the full x.
REQ-023 HOLD: alu_start=0, alu_sel and alu_inbus unchanged for M_DELAY cycles, then WAIT.
REQ-024 WAIT: alu_inbus={8'h00, y}, alu_sel=op held; cycle counter increments each cycle.
REQ-025 WAIT: rsp_of accumulator SHALL OR in alu_of_flag every cycle from START through WAIT.
REQ-026 WAIT with alu_finish=1: capture alu_outbus into rsp_data, rsp_timeout=0, go RESP next cycle.
REQ-027 WAIT with counter=TIMEOUT and no finish: rsp_data=0, rsp_timeout=1, rsp_of=0, go RESP.
REQ-028 alu_finish and timeout in the same cycle SHALL resolve as finish.
REQ-029 RESP: rsp_valid=1, rsp_data/rsp_of/rsp_timeout stable until rsp_ready; then IDLE.
REQ-030 cmd_ready SHALL be 0 in every state except IDLE; no command queuing.
REQ-031 Command-to-ALU-start latency SHALL be 2 cycles after handshake edge (CLR, then START).
REQ-032 alu_finish or alu_of_flag outside WAIT/START SHALL be ignored.

Reset
REQ-033 rst low SHALL immediately force IDLE, clear counter, rsp_data=0, rsp_of=0, rsp_timeout=0, rsp_valid=0.
REQ-034 During reset alu_start=0, alu_sel=0, alu_inbus=0, alu_rst=1; after release alu_rst=0 and cmd_ready=1.
REQ-035 Reset mid-operation SHALL drop the operation with no response.

Structure
REQ-036 Op encodings and the state enumeration SHALL live in shared package alu_pkg.
REQ-037 The WAIT cycle counter with terminal compare SHALL be sub-module alu_seq_timer (width ceil(log2(TIMEOUT+1))).

Verification
REQ-038 add x=20, y=75 -> rsp_data=16'd95, rsp_of=0, rsp_timeout=0.
REQ-039 add x=8'h7F, y=8'h7E -> rsp_data low byte 8'hFD, rsp_of=1.
REQ-040 mul x=8'hE9 (-23), y=8'h4B (75) -> rsp_data=16'hF943, rsp_of=0.
REQ-041 div x=16'd5771, y=8'd125 -> completes with rsp_timeout=0; rsp_ready low 5 cycles -> rsp_data stable, cmd_ready=0 throughout.
REQ-042 model with alu_finish tied 0 -> rsp_valid after START+M_DELAY+TIMEOUT+1 cycles, rsp_timeout=1, rsp_data=0.
REQ-043 rst low during WAIT -> next cycle state IDLE, rsp_valid=0, alu_rst=1; a new add 1+1 after release returns 16'd2.
